cook_timer_controller: RTL and testbench

- Sequencer between the keypad input encoder and the 4-digit MM:SS display/countdown path.
- Consumes the encoder's `load` strobe, BCD `digit` and 1 Hz square wave `pgt_1hz`.
- Shifts keyed digits into a BCD time register, then counts it down once per second under start/stop/door control.
- Drives `running` for the load (heater/motor) and `done` at zero.

---
 rtl/cook_timer_controller.sv | 205 ++++++++++++++++++++
 tb/tb_cook_timer_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cook_timer_controller.sv
// Cook timer sequencer: keypad digit entry into an MM:SS BCD register, 1 Hz countdown with start/stop/door control.
// Optional macro DONE_ALARM_EN: `done` alarm toggles per tick and self-clears after DONE_TICKS ticks.
module cook_timer_controller #(
  parameter int DONE_TICKS  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       pgt_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done
);

  if (SYNC_STAGES < 2 || DONE_TICKS < 1) begin : g_param_check
    $error("cook_timer_controller: SYNC_STAGES must be >= 2 and DONE_TICKS >= 1");
  end

  typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] tmr, tmr_next;
  logic        done_next;

  logic [SYNC_STAGES-1:0] load_sync, start_sync, stop_sync, door_sync, tick_sync;
  logic [3:0]             digit_sync [SYNC_STAGES];
  logic                   load_prev, start_prev, stop_prev, tick_prev;

  // NOTE: every flop, including the digit pipeline array, is reset so no X can reach the events.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      load_sync  <= '0;
      start_sync <= '1;
      stop_sync  <= '1;
      door_sync  <= '0;
      tick_sync  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) digit_sync[i] <= '0;
      load_prev  <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      tick_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      load_sync  <= {load_sync[SYNC_STAGES-2:0], load};
      start_sync <= {start_sync[SYNC_STAGES-2:0], startn};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stopn};
      door_sync  <= {door_sync[SYNC_STAGES-2:0], door_closed};
      tick_sync  <= {tick_sync[SYNC_STAGES-2:0], pgt_1hz};
      digit_sync[0] <= digit;
      for (int i = 1; i < SYNC_STAGES; i++) digit_sync[i] <= digit_sync[i-1];
      load_prev  <= load_sync[SYNC_STAGES-1];
      start_prev <= start_sync[SYNC_STAGES-1];
      stop_prev  <= stop_sync[SYNC_STAGES-1];
      tick_prev  <= tick_sync[SYNC_STAGES-1];
    end
  end

  logic       load_ev, start_ev, stop_ev, tick, door_ok, digit_ok;
  logic [3:0] digit_now;

  assign load_ev   = load_sync[SYNC_STAGES-1] & ~load_prev;
  assign start_ev  = ~start_sync[SYNC_STAGES-1] & start_prev;
  assign stop_ev   = ~stop_sync[SYNC_STAGES-1] & stop_prev;
  assign tick      = tick_sync[SYNC_STAGES-1] & ~tick_prev;
  assign door_ok   = door_sync[SYNC_STAGES-1];
  assign digit_now = digit_sync[SYNC_STAGES-1];
  assign digit_ok  = (digit_now <= 4'd9);

  // Entered seconds above 59 are not normalised; only a borrow into a zero digit wraps.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  logic [15:0] tmr_dec;
  assign tmr_dec = bcd_dec(tmr);

`ifdef DONE_ALARM_EN
  localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  logic [CW-1:0] alarm_cnt, alarm_cnt_next;
`endif

  // NOTE: all outputs of this block get a default first so no latches are inferred.
  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    done_next  = 1'b0;
`ifdef DONE_ALARM_EN
    alarm_cnt_next = alarm_cnt;
`endif
    unique case (state)
      IDLE: begin
        tmr_next = '0;
        if (load_ev && digit_ok) begin
          tmr_next   = {12'h000, digit_now};
          state_next = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_ev) begin
          tmr_next   = '0;
          state_next = IDLE;
        end else if (start_ev && door_ok && tmr != '0) begin
          state_next = RUN;
        end else if (load_ev && digit_ok) begin
          tmr_next = {tmr[11:0], digit_now};
        end
      end
      RUN: begin
        if (stop_ev || !door_ok) begin
          state_next = PAUSE;
        end else if (tick) begin
          tmr_next = tmr_dec;
          if (tmr_dec == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
`ifdef DONE_ALARM_EN
            alarm_cnt_next = '0;
`endif
          end
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          tmr_next   = '0;
          state_next = IDLE;
        end else if (start_ev && door_ok) begin
          state_next = RUN;
        end
      end
      DONE: begin
        tmr_next  = '0;
        done_next = done;
        if (stop_ev) begin
          state_next = IDLE;
          done_next  = 1'b0;
        end else if (load_ev && digit_ok) begin
          tmr_next   = {12'h000, digit_now};
          state_next = ENTRY;
          done_next  = 1'b0;
        end
`ifdef DONE_ALARM_EN
        else if (tick) begin
          if (alarm_cnt == CW'(DONE_TICKS - 1)) begin
            state_next = IDLE;
            done_next  = 1'b0;
          end else begin
            alarm_cnt_next = alarm_cnt + 1'b1;
            done_next      = ~done;
          end
        end
`endif
      end
      default: begin
        tmr_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      tmr     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
`ifdef DONE_ALARM_EN
      alarm_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      tmr     <= tmr_next;
      running <= (state_next == RUN);
      done    <= done_next;
`ifdef DONE_ALARM_EN
      alarm_cnt <= alarm_cnt_next;
`endif
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = tmr;

endmodule

// File: tb/tb_cook_timer_controller.sv
// Directed bench for cook_timer_controller: entry, countdown, pause, stop/start priority and done behaviour.
module tb_cook_timer_controller;

  logic       clk = 1'b0;
  logic       clear, load, pgt_1hz, startn, stopn, door_closed;
  logic [3:0] digit;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, done;

  int total = 0;
  int bad   = 0;

  cook_timer_controller #(.DONE_TICKS(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .clear(clear), .load(load), .digit(digit), .pgt_1hz(pgt_1hz),
    .startn(startn), .stopn(stopn), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit = d; load = 1'b1; cyc(20);
    load = 1'b0; cyc(10);
  endtask

  task automatic start_btn();
    startn = 1'b0; cyc(6);
    startn = 1'b1; cyc(6);
  endtask

  task automatic stop_btn();
    stopn = 1'b0; cyc(6);
    stopn = 1'b1; cyc(6);
  endtask

  task automatic tick();
    pgt_1hz = 1'b1; cyc(6);
    pgt_1hz = 1'b0; cyc(6);
  endtask

  function automatic logic [15:0] tm();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    clear = 1'b1; load = 1'b0; digit = 4'd0; pgt_1hz = 1'b0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1;
    cyc(3);
    check("reset_time", tm(), 16'h0000);
    check("reset_run", running, 0);
    check("reset_done", done, 0);
    clear = 1'b0; cyc(2);

    // Latency and hold: one digit, SYNC_STAGES+1 clocks after load rises.
    digit = 4'd1; load = 1'b1; cyc(2);
    check("latency_early", tm(), 16'h0000);
    cyc(1);
    check("latency_on", tm(), 16'h0001);
    cyc(1000);
    check("hold_one_digit", tm(), 16'h0001);
    load = 1'b0; cyc(10);
    press(4'd3);
    check("entry_13", tm(), 16'h0013);
    press(4'd0);
    check("entry_130", tm(), 16'h0130);

    // Reset mid-RUN clears everything asynchronously.
    start_btn();
    check("run_0130", running, 1);
    tick();
    check("first_dec", tm(), 16'h0129);
    clear = 1'b1; #2;
    check("async_rst_time", tm(), 16'h0000);
    check("async_rst_run", running, 0);
    check("async_rst_done", done, 0);
    cyc(2); clear = 1'b0; cyc(2);

    // Five digits: oldest pushed out; invalid digit ignored; stop clears.
    for (int i = 1; i <= 5; i++) press(4'(i));
    check("five_digits", tm(), 16'h2345);
    press(4'd12);
    check("invalid_digit", tm(), 16'h2345);
    stop_btn();
    check("entry_stop", tm(), 16'h0000);
    start_btn();
    check("start_zero", running, 0);

    // 0:03 countdown to DONE.
    press(4'd3);
    door_closed = 1'b0; cyc(5);
    start_btn();
    check("start_door_open", running, 0);
    door_closed = 1'b1; cyc(5);
    start_btn();
    check("start_ok", running, 1);
    tick(); tick();
    check("cnt_0001", tm(), 16'h0001);
    check("cnt_done_early", done, 0);
    tick();
    check("cnt_zero", tm(), 16'h0000);
    check("done_entry", done, 1);
    check("done_run", running, 0);
`ifdef DONE_ALARM_EN
    tick();
    check("alarm_t1", done, 0);
    tick();
    check("alarm_t2", done, 1);
    tick();
    check("alarm_t3", done, 0);
    press(4'd7);
    check("alarm_idle_entry", tm(), 16'h0007);
    stop_btn();
`else
    repeat (10) tick();
    check("done_held", done, 1);
    check("done_held_time", tm(), 16'h0000);
    stop_btn();
    check("done_stop", done, 0);
`endif

    // Pause on door open, resume with start.
    press(4'd1); press(4'd0); press(4'd0);
    start_btn();
    tick();
    check("run_0059", tm(), 16'h0059);
    door_closed = 1'b0; cyc(5);
    check("door_pause", running, 0);
    repeat (5) tick();
    check("pause_held", tm(), 16'h0059);
    door_closed = 1'b1; cyc(5);
    check("no_auto_resume", running, 0);
    start_btn();
    check("resume", running, 1);
    tick();
    check("run_0058", tm(), 16'h0058);

    // Stop and start together act as stop.
    startn = 1'b0; stopn = 1'b0; cyc(6);
    check("stop_start_pause", running, 0);
    startn = 1'b1; stopn = 1'b1; cyc(6);
    tick();
    check("stop_start_held", tm(), 16'h0058);
    stop_btn();
    check("pause_stop", tm(), 16'h0000);

    // Literal countdown of an out-of-range seconds entry, and minute borrow.
    press(4'd7); press(4'd8); press(4'd5);
    start_btn();
    repeat (85) tick();
    check("lit_0700", tm(), 16'h0700);
    tick();
    check("lit_0659", tm(), 16'h0659);
    stop_btn(); stop_btn();
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    start_btn();
    tick();
    check("borrow_0959", tm(), 16'h0959);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
